// File: rtl/out_port_arb.sv
// Output-port allocator: round-robin over five input FIFOs with wormhole locking and credit flow control.
// Optional lock watchdog is enabled by defining ARB_WDOG_EN.
module out_port_arb #(
    parameter int DATAW      = 31,
    parameter int CREDITS    = 4,
    parameter int WDOG_LIMIT = 255,
    localparam int CW        = $clog2(CREDITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [5*(DATAW+1)-1:0] in_data,
    input  logic [4:0]             in_empty,
    input  logic [4:0]             in_req,
    output logic [4:0]             in_rd_en,
    output logic [DATAW:0]         out_data,
    output logic                   out_wr_en,
    input  logic                   credit_in,
    output logic [CW-1:0]          credit_cnt,
    output logic [4:0]             grant,
    output logic                   busy
`ifdef ARB_WDOG_EN
    ,
    output logic                   wdog_err
`endif
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    if (CREDITS < 1 || WDOG_LIMIT < 1) begin : g_bad_params
        $error("out_port_arb: CREDITS and WDOG_LIMIT must be at least 1");
    end

    state_t          state;
    logic [2:0]      owner;
    logic [2:0]      rr_ptr;
    logic [DATAW:0]  flit [5];
    logic [4:0]      eligible;
    logic [2:0]      idx;
    logic [2:0]      pick;
    logic            pick_vld;
    logic [2:0]      src;
    logic            send;
    logic [1:0]      src_type;

`ifdef ARB_WDOG_EN
    localparam int WCW = $clog2(WDOG_LIMIT + 1);
    logic [WCW-1:0]  wdog_cnt;
`endif

    // Head flits (type 01 or 11) both have bit DATAW-1 set.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            flit[i]     = in_data[i*(DATAW+1) +: DATAW+1];
            eligible[i] = in_req[i] & ~in_empty[i] & flit[i][DATAW-1];
        end
    end

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 1; k <= 5; k++) begin
            idx = 3'((32'(rr_ptr) + k) % 5);
            if (!pick_vld && eligible[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        send = 1'b0;
        src  = owner;
        if (!rst_ && credit_cnt != '0) begin
            if (state == IDLE) begin
                if (pick_vld) begin
                    send = 1'b1;
                    src  = pick;
                end
            end else if (!in_empty[owner]) begin
                send = 1'b1;
            end
        end
        in_rd_en = send ? (5'b00001 << src) : 5'b00000;
        src_type = flit[src][DATAW:DATAW-1];
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= 3'd4;
            credit_cnt <= CW'(CREDITS);
            out_data   <= '0;
            out_wr_en  <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
`ifdef ARB_WDOG_EN
            wdog_cnt   <= '0;
            wdog_err   <= 1'b0;
`endif
        end else begin
            out_wr_en <= send;
            if (send) begin
                out_data <= flit[src];
            end

            // Credit returns saturate so a spurious pulse cannot wrap the counter.
            if (send && !credit_in) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (!send && credit_in && credit_cnt != CW'(CREDITS)) begin
                credit_cnt <= credit_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (send) begin
                        rr_ptr <= src;
                        if (src_type == T_HEAD) begin
                            state <= LOCK;
                            owner <= src;
                            grant <= 5'b00001 << src;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (send) begin
`ifdef ARB_WDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (src_type == T_TAIL) begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end
`ifdef ARB_WDOG_EN
                    else if (wdog_cnt == WCW'(WDOG_LIMIT - 1)) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        wdog_cnt <= '0;
                        wdog_err <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_arb.sv
// Randomized bench for out_port_arb: queue-based input FIFOs and a packet-level model, plus directed cases.
// Define ARB_WDOG_EN to also exercise the lock watchdog.
module tb_out_port_arb;

    localparam int DATAW      = 31;
    localparam int CREDITS    = 4;
    localparam int WDOG_LIMIT = 8;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [159:0] in_data = '0;
    logic [4:0]   in_empty = 5'h1f;
    logic [4:0]   in_req = '0;
    logic [4:0]   in_rd_en;
    logic [31:0]  out_data;
    logic         out_wr_en;
    logic         credit_in = 1'b0;
    logic [2:0]   credit_cnt;
    logic [4:0]   grant;
    logic         busy;
`ifdef ARB_WDOG_EN
    logic         wdog_err;
`endif

    always #5 clk = ~clk;

    out_port_arb #(.DATAW(DATAW), .CREDITS(CREDITS), .WDOG_LIMIT(WDOG_LIMIT)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .in_data    (in_data),
        .in_empty   (in_empty),
        .in_req     (in_req),
        .in_rd_en   (in_rd_en),
        .out_data   (out_data),
        .out_wr_en  (out_wr_en),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .grant      (grant),
        .busy       (busy)
`ifdef ARB_WDOG_EN
        ,
        .wdog_err   (wdog_err)
`endif
    );

    logic [31:0] fq [5][$];
    bit          stall [5];
    logic [4:0]  req_v;
    bit          cin_v;
    bit          rand_mode;
    int          ds_cnt;
    logic [4:0]  cap_rd;
    int          n_cmp;
    int          n_fail;

    // Packet-level model: who holds the output, last winner, credits, last forwarded flit.
    bit          m_lock;
    int          m_owner;
    int          m_last;
    int          m_cred;
    int          m_wd;
    bit          m_err;
    logic [31:0] m_data;
    bit          m_wr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_lock  = 1'b0;
        m_owner = 0;
        m_last  = 4;
        m_cred  = CREDITS;
        m_wd    = 0;
        m_err   = 1'b0;
        m_data  = '0;
        m_wr    = 1'b0;
    endfunction

    function automatic bit isHeadType(input logic [31:0] f);
        logic [1:0] t;
        t = f[31:30];
        return (t == 2'b01) || (t == 2'b11);
    endfunction

    function automatic logic [31:0] mkFlit(input logic [1:0] t);
        return {t, 30'($urandom)};
    endfunction

    // One clock: drive inputs at negedge, compare against the model, then advance FIFOs and model.
    task automatic applyStimulus();
        int          pop;
        int          i;
        int          len;
        logic [31:0] pf;
        logic [4:0]  exp_rd;
        bit          avail [5];
        @(negedge clk);
        if (rand_mode) begin
            for (int p = 0; p < 5; p++) begin
                while (fq[p].size() > 0 && !isHeadType(fq[p][0]) && !(m_lock && m_owner == p))
                    void'(fq[p].pop_front());
                if (fq[p].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        if (len == 1)           fq[p].push_back(mkFlit(2'b11));
                        else if (j == 0)        fq[p].push_back(mkFlit(2'b01));
                        else if (j == len - 1)  fq[p].push_back(mkFlit(2'b10));
                        else                    fq[p].push_back(mkFlit(2'b00));
                    end
                end
                stall[p]  = ($urandom_range(0, 4) == 0);
                req_v[p]  = ($urandom_range(0, 9) < 7);
            end
            if (ds_cnt > 0 && $urandom_range(0, 99) < 40) begin
                cin_v = 1'b1;
                ds_cnt--;
            end else begin
                cin_v = ($urandom_range(0, 99) < 3);
            end
        end
        for (int p = 0; p < 5; p++) begin
            avail[p]             = (fq[p].size() > 0) && !stall[p];
            in_empty[p]          = !avail[p];
            in_data[p*32 +: 32]  = (fq[p].size() > 0) ? fq[p][0] : 32'h0;
        end
        in_req    = req_v;
        credit_in = cin_v;
        #1;
        if (rst_) modelReset();

        pop = -1;
        pf  = '0;
        if (!rst_ && m_cred > 0) begin
            if (!m_lock) begin
                for (int k = 1; k <= 5; k++) begin
                    i = (m_last + k) % 5;
                    if (pop < 0 && req_v[i] && avail[i] && isHeadType(fq[i][0])) pop = i;
                end
            end else if (avail[m_owner]) begin
                pop = m_owner;
            end
        end
        if (pop >= 0) pf = fq[pop][0];
        exp_rd = (pop >= 0) ? 5'(1 << pop) : 5'b0;

        checkOutput("in_rd_en",   32'(in_rd_en),   32'(exp_rd));
        checkOutput("out_wr_en",  32'(out_wr_en),  32'(m_wr));
        checkOutput("out_data",   out_data,        m_data);
        checkOutput("credit_cnt", 32'(credit_cnt), 32'(m_cred));
        checkOutput("grant",      32'(grant),      m_lock ? (32'd1 << m_owner) : 32'd0);
        checkOutput("busy",       32'(busy),       32'(m_lock));
`ifdef ARB_WDOG_EN
        checkOutput("wdog_err",   32'(wdog_err),   32'(m_err));
`endif
        cap_rd = in_rd_en;

        @(posedge clk);
        for (int p = 0; p < 5; p++) begin
            if (cap_rd[p] && fq[p].size() > 0) begin
                void'(fq[p].pop_front());
                ds_cnt++;
            end
        end
        if (rst_) begin
            modelReset();
        end else begin
            if (!m_lock) begin
                if (pop >= 0) begin
                    m_last = pop;
                    if (pf[31:30] == 2'b01) begin
                        m_lock  = 1'b1;
                        m_owner = pop;
                        m_wd    = 0;
                    end
                end
            end else if (pop >= 0) begin
                m_wd = 0;
                if (pf[31:30] == 2'b10) m_lock = 1'b0;
            end else begin
`ifdef ARB_WDOG_EN
                m_wd++;
                if (m_wd == WDOG_LIMIT) begin
                    m_lock = 1'b0;
                    m_err  = 1'b1;
                    m_wd   = 0;
                end
`endif
            end
            if (pop >= 0 && !cin_v)                        m_cred--;
            else if (pop < 0 && cin_v && m_cred < CREDITS) m_cred++;
            m_wr = (pop >= 0);
            if (pop >= 0) m_data = pf;
        end
    endtask

    task automatic clearEnv();
        for (int p = 0; p < 5; p++) begin
            fq[p].delete();
            stall[p] = 1'b0;
        end
        req_v  = '0;
        cin_v  = 1'b0;
        ds_cnt = 0;
    endtask

    task automatic doReset();
        rand_mode = 1'b0;
        clearEnv();
        #2 rst_ = 1'b1;
        applyStimulus();
        #2 rst_ = 1'b0;
    endtask

    int          wcount;
    logic [31:0] wlog [$];
    int          wcyc [$];
    logic [31:0] exp_seq [6];
    int          guard;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        modelReset();
        clearEnv();

        // Single flit from input 2.
        doReset();
        fq[2].push_back(32'hC0000005);
        req_v = 5'b00100;
        applyStimulus();
        checkOutput("t2_rd_en", 32'(cap_rd), 32'h04);
        #1;
        checkOutput("t2_wr_en", 32'(out_wr_en), 32'h1);
        checkOutput("t2_data", out_data, 32'hC0000005);
        checkOutput("t2_credits", 32'(credit_cnt), 32'd3);
        checkOutput("t2_busy", 32'(busy), 32'd0);

        // Two 3-flit packets competing, credit returned every cycle.
        doReset();
        exp_seq = '{32'h40000A00, 32'h00000A01, 32'h80000A02,
                    32'h40000B00, 32'h00000B01, 32'h80000B02};
        for (int j = 0; j < 3; j++) fq[0].push_back(exp_seq[j]);
        for (int j = 3; j < 6; j++) fq[3].push_back(exp_seq[j]);
        req_v = 5'b01001;
        cin_v = 1'b1;
        wlog.delete();
        wcyc.delete();
        for (int c = 0; c < 8; c++) begin
            applyStimulus();
            #1;
            if (out_wr_en) begin
                wlog.push_back(out_data);
                wcyc.push_back(c);
            end
        end
        checkOutput("t3_count", 32'(wlog.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < wlog.size()) begin
                checkOutput("t3_order", wlog[j], exp_seq[j]);
                checkOutput("t3_cycle", 32'(wcyc[j]), 32'(j));
            end
        end

        // Credit exhaustion mid-packet, then a single credit releases the tail.
        doReset();
        fq[1].push_back(32'h40000100);
        fq[1].push_back(32'h00000101);
        fq[1].push_back(32'h00000102);
        fq[1].push_back(32'h00000103);
        fq[1].push_back(32'h80000104);
        req_v  = 5'b00010;
        wcount = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            #1;
            if (out_wr_en) wcount++;
        end
        checkOutput("t4_sent", 32'(wcount), 32'd4);
        checkOutput("t4_busy", 32'(busy), 32'd1);
        checkOutput("t4_credits0", 32'(credit_cnt), 32'd0);
        cin_v = 1'b1;
        applyStimulus();
        cin_v = 1'b0;
        applyStimulus();
        checkOutput("t4_tail_rd", 32'(cap_rd), 32'h02);
        #1;
        checkOutput("t4_tail_data", out_data, 32'h80000104);
        checkOutput("t4_credits_end", 32'(credit_cnt), 32'd0);
        checkOutput("t4_idle", 32'(busy), 32'd0);

        // Simultaneous pop and credit, then saturation at full.
        doReset();
        fq[0].push_back(32'hC0000010);
        fq[2].push_back(32'hC0000012);
        req_v = 5'b00101;
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("t5_credits2", 32'(credit_cnt), 32'd2);
        fq[3].push_back(32'hC0000013);
        req_v = 5'b01000;
        cin_v = 1'b1;
        applyStimulus();
        #1;
        checkOutput("t5_both", 32'(credit_cnt), 32'd2);
        checkOutput("t5_data", out_data, 32'hC0000013);
        doReset();
        cin_v = 1'b1;
        applyStimulus();
        #1;
        checkOutput("t5_saturate", 32'(credit_cnt), 32'd4);

`ifdef ARB_WDOG_EN
        // Owner starves after its head: watchdog releases the lock.
        doReset();
        fq[1].push_back(32'h40000011);
        req_v = 5'b00010;
        applyStimulus();
        fq[4].push_back(32'hC0000044);
        req_v = 5'b10000;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus();
            #1;
            if (c == 7) begin
                checkOutput("t6_err_early", 32'(wdog_err), 32'd0);
                checkOutput("t6_still_busy", 32'(busy), 32'd1);
            end
        end
        checkOutput("t6_err", 32'(wdog_err), 32'd1);
        checkOutput("t6_idle", 32'(busy), 32'd0);
        checkOutput("t6_grant", 32'(grant), 32'd0);
        applyStimulus();
        checkOutput("t6_next_grant", 32'(cap_rd), 32'h10);
`endif

        // Random traffic against the model.
        doReset();
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) applyStimulus();

        // Reset in the middle of a locked packet.
        guard = 0;
        while (!m_lock && guard < 200) begin
            applyStimulus();
            guard++;
        end
        checkOutput("t1_lock_seen", 32'(m_lock), 32'd1);
        rand_mode = 1'b0;
        #2 rst_ = 1'b1;
        applyStimulus();
        checkOutput("t1_rd_en", 32'(cap_rd), 32'd0);
        #1;
        checkOutput("t1_credits", 32'(credit_cnt), 32'd4);
        checkOutput("t1_grant", 32'(grant), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_wr_en", 32'(out_wr_en), 32'd0);
        clearEnv();
        #1 rst_ = 1'b0;
        for (int c = 0; c < 4; c++) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
